// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate data cache, 64 B lines, 64-bit Mem-stage port.
// Optional line flush walker enabled with `define DCACHE_FLUSH_EN (adds flush/flush_done).
module dcache_wb #(
    parameter int LINES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         wenable,
    input  logic [63:0]  addr,
    input  logic [63:0]  wdata,
    output logic [63:0]  rdata,
    output logic         done,
    output logic         mem_req,
    output logic         mem_wr,
    output logic [63:0]  mem_addr,
    output logic [511:0] mem_wdata,
    input  logic [511:0] mem_rdata,
    input  logic         mem_done
`ifdef DCACHE_FLUSH_EN
    ,
    input  logic         flush,
    output logic         flush_done
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 58 - IDX_W;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, WRBACK, GAP, REFILL, RESPOND
`ifdef DCACHE_FLUSH_EN
        , FL_SCAN, FL_WB, FL_GAP, FL_DONE
`endif
    } state_t;

    state_t state, next;

    logic [60:0]      req_wa;
    logic             req_we;
    logic [63:0]      req_wdata;
    logic [2:0]       req_word;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;

    logic [LINES-1:0] valid, dirty;
    logic [TAG_W-1:0] tags  [LINES];
    logic [511:0]     lines [LINES];

    logic             hit;
    logic [511:0]     refill_line;
    logic             unused_bits;

    assign unused_bits = ^addr[2:0];
    assign req_word    = req_wa[2:0];
    assign req_idx     = req_wa[3 +: IDX_W];
    assign req_tag     = req_wa[60 -: TAG_W];
    assign hit         = valid[req_idx] && (tags[req_idx] == req_tag);

    function automatic logic [511:0] merge(input logic [511:0] l, input logic [2:0] w,
                                           input logic [63:0] d);
        logic [511:0] r;
        r = l;
        r[{w, 6'b0} +: 64] = d;
        return r;
    endfunction

    assign refill_line = req_we ? merge(mem_rdata, req_word, req_wdata) : mem_rdata;

`ifdef DCACHE_FLUSH_EN
    logic [IDX_W-1:0] flush_idx;
    logic             flush_last;
    assign flush_last = (flush_idx == IDX_W'(LINES - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next      = state;
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
`ifdef DCACHE_FLUSH_EN
        flush_done = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef DCACHE_FLUSH_EN
                if (flush)       next = FL_SCAN;
                else if (enable) next = LOOKUP;
`else
                if (enable) next = LOOKUP;
`endif
            end
            LOOKUP: begin
                if (hit)                                    next = RESPOND;
                else if (valid[req_idx] && dirty[req_idx]) next = WRBACK;
                else                                        next = REFILL;
            end
            WRBACK: begin
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {tags[req_idx], req_idx, 6'b0};
                mem_wdata = lines[req_idx];
                if (mem_done) next = GAP;
            end
            // One idle cycle lets the arbiter see mem_req fall between the two transactions.
            GAP: next = REFILL;
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx, 6'b0};
                if (mem_done) next = RESPOND;
            end
            RESPOND: begin
                done = 1'b1;
                next = IDLE;
            end
`ifdef DCACHE_FLUSH_EN
            FL_SCAN: begin
                if (valid[flush_idx] && dirty[flush_idx]) next = FL_WB;
                else if (flush_last)                     next = FL_DONE;
            end
            FL_WB: begin
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {tags[flush_idx], flush_idx, 6'b0};
                mem_wdata = lines[flush_idx];
                if (mem_done) next = FL_GAP;
            end
            FL_GAP: next = flush_last ? FL_DONE : FL_SCAN;
            FL_DONE: begin
                flush_done = 1'b1;
                next       = IDLE;
            end
`endif
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid     <= '0;
            dirty     <= '0;
            rdata     <= '0;
            req_wa    <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
`ifdef DCACHE_FLUSH_EN
            flush_idx <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        req_wa    <= addr[63:3];
                        req_we    <= wenable;
                        req_wdata <= wdata;
                    end
`ifdef DCACHE_FLUSH_EN
                    flush_idx <= '0;
`endif
                end
                LOOKUP: begin
                    if (hit) begin
                        if (req_we) begin
                            lines[req_idx][{req_word, 6'b0} +: 64] <= req_wdata;
                            dirty[req_idx] <= 1'b1;
                            rdata          <= req_wdata;
                        end else begin
                            rdata <= lines[req_idx][{req_word, 6'b0} +: 64];
                        end
                    end
                end
                REFILL: begin
                    if (mem_done) begin
                        lines[req_idx] <= refill_line;
                        tags[req_idx]  <= req_tag;
                        valid[req_idx] <= 1'b1;
                        dirty[req_idx] <= req_we;
                        rdata          <= refill_line[{req_word, 6'b0} +: 64];
                    end
                end
`ifdef DCACHE_FLUSH_EN
                FL_SCAN: begin
                    if (!(valid[flush_idx] && dirty[flush_idx]) && !flush_last)
                        flush_idx <= flush_idx + 1'b1;
                end
                FL_WB: begin
                    if (mem_done) dirty[flush_idx] <= 1'b0;
                end
                FL_GAP: begin
                    if (!flush_last) flush_idx <= flush_idx + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: line memory responder, transaction log and done-latency checks.
module tb_dcache_wb;

    localparam int MEM_LAT = 3;

    logic         clk = 1'b0;
    logic         reset, enable, wenable, done, mem_req, mem_wr, mem_done;
    logic [63:0]  addr, wdata, rdata, mem_addr;
    logic [511:0] mem_wdata, mem_rdata;
`ifdef DCACHE_FLUSH_EN
    logic         flush, flush_done;
`endif

    dcache_wb #(.LINES(64)) dut (
        .clk(clk), .reset(reset), .enable(enable), .wenable(wenable), .addr(addr),
        .wdata(wdata), .rdata(rdata), .done(done), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done)
`ifdef DCACHE_FLUSH_EN
        , .flush(flush), .flush_done(flush_done)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic [63:0]  addr;
        logic [511:0] wdata;
        int           start;
    } tx_t;

    tx_t          txq[$];
    logic [511:0] mem [logic [63:0]];
    int           cyc = 0;
    int           done_cnt = 0;
    int           passed = 0;
    int           total = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
    end

    // Line memory: responds MEM_LAT cycles after it first sees mem_req.
    initial begin
        int lat_cnt;
        int start;
        tx_t t;
        lat_cnt   = 0;
        start     = 0;
        mem_done  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_done = 1'b0;
            if (reset || !mem_req) begin
                lat_cnt = 0;
            end else begin
                lat_cnt++;
                if (lat_cnt == 1) start = cyc;
                if (lat_cnt == MEM_LAT) begin
                    t.wr = mem_wr; t.addr = mem_addr; t.wdata = mem_wdata; t.start = start;
                    txq.push_back(t);
                    if (mem_wr) mem[mem_addr] = mem_wdata;
                    else        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : '0;
                    mem_done = 1'b1;
                    lat_cnt  = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Entered and left just after a rising edge; lat counts edges until done is seen high.
    task automatic req(input logic we, input logic [63:0] a, input logic [63:0] d,
                       output logic [63:0] rd, output int lat);
        int  s;
        bit  got;
        enable = 1'b1; wenable = we; addr = a; wdata = d;
        s = cyc; got = 0; lat = -1; rd = '0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1; lat = cyc - s; rd = rdata;
            end
        end
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    initial begin
        logic [63:0]  rd;
        logic [511:0] line;
        int           lat, n0, d0, s1, s2, d1, d2;
        bit           got;

        reset = 1'b1; enable = 1'b0; wenable = 1'b0; addr = '0; wdata = '0;
`ifdef DCACHE_FLUSH_EN
        flush = 1'b0;
`endif
        line = '0; line[63:0] = 64'hDEADBEEF; line[127:64] = 64'h1111;
        mem[64'h1000] = line;
        line = '0; line[63:0] = 64'h2222;
        mem[64'h2000] = line;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_mem_wr", {63'd0, mem_wr}, 64'd0);
        check("rst_rdata", rdata, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", {63'd0, |mem_wdata}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Cold read miss
        req(1'b0, 64'h1000, 64'd0, rd, lat);
        check("miss_rdata", rd, 64'hDEADBEEF);
        check("miss_lat", 64'(lat), 64'd5);
        check("miss_ntx", 64'(txq.size()), 64'd1);
        check("miss_tx_wr", {63'd0, txq[0].wr}, 64'd0);
        check("miss_tx_addr", txq[0].addr, 64'h1000);

        req(1'b0, 64'h1008, 64'd0, rd, lat);
        check("hit_rdata", rd, 64'h1111);
        check("hit_lat", 64'(lat), 64'd2);
        check("hit_ntx", 64'(txq.size()), 64'd1);

        req(1'b1, 64'h1010, 64'h1122334455667788, rd, lat);
        check("whit_lat", 64'(lat), 64'd2);
        check("whit_ntx", 64'(txq.size()), 64'd1);

        // Dirty victim: write-back, gap, refill
        req(1'b0, 64'h2000, 64'd0, rd, lat);
        check("dmiss_rdata", rd, 64'h2222);
        check("dmiss_lat", 64'(lat), 64'd9);
        check("dmiss_ntx", 64'(txq.size()), 64'd3);
        check("wb_wr", {63'd0, txq[1].wr}, 64'd1);
        check("wb_addr", txq[1].addr, 64'h1000);
        check("wb_word2", txq[1].wdata[191:128], 64'h1122334455667788);
        check("wb_word0", txq[1].wdata[63:0], 64'hDEADBEEF);
        check("rf_wr", {63'd0, txq[2].wr}, 64'd0);
        check("rf_addr", txq[2].addr, 64'h2000);
        check("gap_one_cycle", 64'(txq[2].start - txq[1].start), 64'(MEM_LAT + 1));

        // Write miss with clean victim
        req(1'b1, 64'h3018, 64'hA5A5, rd, lat);
        check("wmiss_lat", 64'(lat), 64'd5);
        check("wmiss_ntx", 64'(txq.size()), 64'd4);
        check("wmiss_tx_wr", {63'd0, txq[3].wr}, 64'd0);
        check("wmiss_tx_addr", txq[3].addr, 64'h3000);
        req(1'b0, 64'h3018, 64'd0, rd, lat);
        check("wmiss_reread", rd, 64'hA5A5);
        check("wmiss_reread_lat", 64'(lat), 64'd2);

        // Reset during a refill
        enable = 1'b1; wenable = 1'b0; addr = 64'h4040;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (mem_req) got = 1;
        end
        check("abort_saw_req", {63'd0, got}, 64'd1);
        d0 = done_cnt; n0 = txq.size();
        reset = 1'b1; enable = 1'b0;
        @(negedge clk);
        check("abort_mem_req", {63'd0, mem_req}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 64'(d0));
        check("abort_no_tx", 64'(txq.size()), 64'(n0));
        @(posedge clk);
        #1;

        // Valid bits cleared: miss without write-back even though 0x3000 was dirty
        req(1'b0, 64'h1000, 64'd0, rd, lat);
        check("post_rst_lat", 64'(lat), 64'd5);
        check("post_rst_ntx", 64'(txq.size()), 64'(n0 + 1));
        check("post_rst_tx_wr", {63'd0, txq[n0].wr}, 64'd0);
        check("post_rst_rdata", rd, 64'hDEADBEEF);

`ifdef DCACHE_FLUSH_EN
        req(1'b1, 64'h00C0, 64'h33, rd, lat);
        req(1'b1, 64'h01C0, 64'h77, rd, lat);
        n0 = txq.size();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        d1 = 0; got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (flush_done) d1++;
        end
        check("flush_pulses", 64'(d1), 64'd1);
        check("flush_ntx", 64'(txq.size()), 64'(n0 + 2));
        check("flush_wb0_addr", txq[n0].addr, 64'h00C0);
        check("flush_wb0_data", txq[n0].wdata[63:0], 64'h33);
        check("flush_wb1_addr", txq[n0+1].addr, 64'h01C0);
        check("flush_wb1_wr", {63'd0, txq[n0+1].wr}, 64'd1);
        @(posedge clk);
        #1;
        req(1'b0, 64'h00C0, 64'd0, rd, lat);
        check("flush_reread_lat", 64'(lat), 64'd2);
        check("flush_reread", rd, 64'h33);
`endif

        // Back-to-back: enable stays high across done, address moves on
        enable = 1'b1; wenable = 1'b0; addr = 64'h1000;
        s1 = cyc; d1 = -1;
        for (int i = 0; i < 50 && d1 < 0; i++) begin
            @(negedge clk);
            if (done) begin d1 = cyc; rd = rdata; end
        end
        check("b2b_first_lat", 64'(d1 - s1), 64'd2);
        check("b2b_first_rdata", rd, 64'hDEADBEEF);
        @(posedge clk);
        #1;
        addr = 64'h1008;
        s2 = cyc; d2 = -1;
        for (int i = 0; i < 50 && d2 < 0; i++) begin
            @(negedge clk);
            if (done) begin d2 = cyc; rd = rdata; end
        end
        check("b2b_second_lat", 64'(d2 - s2), 64'd2);
        check("b2b_second_rdata", rd, 64'h1111);
        @(posedge clk);
        #1;
        enable = 1'b0;
        d0 = done_cnt;
        repeat (4) @(negedge clk);
        check("b2b_no_extra_done", 64'(done_cnt), 64'(d0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
